// File: rtl/dex_pkg.sv
// Shared types and constants for the decode->execute pipeline register.
package dex_pkg;

    localparam logic [3:0] COND_AL        = 4'b1110;
    localparam int         ALUC_W_DEFAULT = 2;

    typedef struct packed {
        logic                      PCSrc;
        logic                      RegWrite;
        logic                      MemWrite;
        logic                      MemtoReg;
        logic                      Branch;
        logic                      ALUSrc;
        logic                      NoWrite;
        logic [1:0]                FlagWrite;
        logic [3:0]                Cond;
        logic [ALUC_W_DEFAULT-1:0] ALUControl;
    } ctrl_t;

    // A bubble never writes state or redirects the PC, and executes as AL (never NV).
    localparam ctrl_t BUBBLE_CTRL = '{
        PCSrc:      1'b0,
        RegWrite:   1'b0,
        MemWrite:   1'b0,
        MemtoReg:   1'b0,
        Branch:     1'b0,
        ALUSrc:     1'b0,
        NoWrite:    1'b0,
        FlagWrite:  2'b00,
        Cond:       COND_AL,
        ALUControl: '0
    };

endpackage

// File: rtl/flopenrc.sv
// Flop with async reset, enable and synchronous clear; reset and clear share RST_VAL.
module flopenrc #(
    parameter type T       = logic,
    parameter T    RST_VAL = T'(0)
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    input  T     d,
    output T     q
);

    // Clear beats enable so a flush wins over a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (clear) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/decode_exec_reg.sv
// Decode->Execute pipeline register with stall, flush and per-slot valid bit.
// Optional DEX_BUBBLE_CNT_EN adds a saturating bubble counter output BubbleCntE.
module decode_exec_reg
    import dex_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int RA_W   = 4,
    parameter int ALUC_W = ALUC_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              ValidD,
    input  logic              PCSrcD,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              MemtoRegD,
    input  logic              BranchD,
    input  logic              ALUSrcD,
    input  logic              NoWriteD,
    input  logic [1:0]        FlagWriteD,
    input  logic [3:0]        CondD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic [WIDTH-1:0]  RD1D,
    input  logic [WIDTH-1:0]  RD2D,
    input  logic [WIDTH-1:0]  ExtImmD,
    input  logic [RA_W-1:0]   RA1D,
    input  logic [RA_W-1:0]   RA2D,
    input  logic [RA_W-1:0]   WA3D,
    output logic              PCSrcEIn,
    output logic              RegWriteEIn,
    output logic              MemWriteEIn,
    output logic              MemtoRegE,
    output logic              BranchEIn,
    output logic              ALUSrcE,
    output logic              NoWrite,
    output logic [1:0]        FlagWriteE,
    output logic [3:0]        CondE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic [WIDTH-1:0]  RD1E,
    output logic [WIDTH-1:0]  RD2E,
    output logic [WIDTH-1:0]  ExtImmE,
    output logic [RA_W-1:0]   RA1E,
    output logic [RA_W-1:0]   RA2E,
    output logic [RA_W-1:0]   WA3E,
`ifdef DEX_BUBBLE_CNT_EN
    output logic [15:0]       BubbleCntE,
`endif
    output logic              ValidE
);

    localparam int DATA_W = 3 * WIDTH + 3 * RA_W;

    ctrl_t              ctrl_d, ctrl_load, ctrl_q;
    logic [DATA_W-1:0]  data_d, data_q;
    logic               load_en;

    assign load_en = ~StallE;

    assign ctrl_d = '{
        PCSrc:      PCSrcD,
        RegWrite:   RegWriteD,
        MemWrite:   MemWriteD,
        MemtoReg:   MemtoRegD,
        Branch:     BranchD,
        ALUSrc:     ALUSrcD,
        NoWrite:    NoWriteD,
        FlagWrite:  FlagWriteD,
        Cond:       CondD,
        ALUControl: ALUControlD
    };

    // An invalid decode slot enters E as a bubble; its data fields are don't-care.
    assign ctrl_load = ValidD ? ctrl_d : BUBBLE_CTRL;
    assign data_d    = {RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D};

    flopenrc #(
        .T       (ctrl_t),
        .RST_VAL (BUBBLE_CTRL)
    ) u_ctrl (
        .clk   (CLK),
        .reset (RESET),
        .en    (load_en),
        .clear (FlushE),
        .d     (ctrl_load),
        .q     (ctrl_q)
    );

    flopenrc #(
        .T (logic [DATA_W-1:0])
    ) u_data (
        .clk   (CLK),
        .reset (RESET),
        .en    (load_en),
        .clear (FlushE),
        .d     (data_d),
        .q     (data_q)
    );

    // ValidE is the slot state: 0 = EMPTY, 1 = FULL.
    flopenrc #(
        .T (logic)
    ) u_valid (
        .clk   (CLK),
        .reset (RESET),
        .en    (load_en),
        .clear (FlushE),
        .d     (ValidD),
        .q     (ValidE)
    );

    assign PCSrcEIn    = ctrl_q.PCSrc;
    assign RegWriteEIn = ctrl_q.RegWrite;
    assign MemWriteEIn = ctrl_q.MemWrite;
    assign MemtoRegE   = ctrl_q.MemtoReg;
    assign BranchEIn   = ctrl_q.Branch;
    assign ALUSrcE     = ctrl_q.ALUSrc;
    assign NoWrite     = ctrl_q.NoWrite;
    assign FlagWriteE  = ctrl_q.FlagWrite;
    assign CondE       = ctrl_q.Cond;
    assign ALUControlE = ctrl_q.ALUControl;
    assign {RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E} = data_q;

`ifdef DEX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q;
    logic        bubble_evt;

    assign bubble_evt = FlushE | (load_en & ~ValidD);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bubble_cnt_q <= '0;
        end else if (bubble_evt && bubble_cnt_q != 16'hFFFF) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign BubbleCntE = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_decode_exec_reg.sv
// Table-driven bench for decode_exec_reg; bubble counter checks under DEX_BUBBLE_CNT_EN.
module tb_decode_exec_reg;

    typedef struct packed {
        logic [6:0]  ctl;  // {PCSrc, RegWrite, MemWrite, MemtoReg, Branch, ALUSrc, NoWrite}
        logic [1:0]  fw;
        logic [3:0]  cond;
        logic [1:0]  aluc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [3:0]  wa3;
    } dvals_t;

    typedef struct {
        logic   stall;
        logic   flush;
        logic   vd;
        dvals_t d;
        dvals_t e;
        logic   e_valid;
    } vec_t;

    localparam dvals_t BUB = '{ctl: 7'b0, fw: 2'b0, cond: 4'b1110, aluc: 2'd0,
        rd1: 32'h0, rd2: 32'h0, imm: 32'h0, ra1: 4'h0, ra2: 4'h0, wa3: 4'h0};
    localparam dvals_t VA = '{ctl: 7'b0100000, fw: 2'b00, cond: 4'b0000, aluc: 2'd0,
        rd1: 32'h0000_00A5, rd2: 32'h0, imm: 32'h0, ra1: 4'h0, ra2: 4'h0, wa3: 4'd3};
    localparam dvals_t VB = '{ctl: 7'b0010000, fw: 2'b00, cond: 4'b0001, aluc: 2'd1,
        rd1: 32'hFFFF_FFFF, rd2: 32'h1111_1111, imm: 32'h22, ra1: 4'h7, ra2: 4'h8, wa3: 4'h5};
    localparam dvals_t VC = '{ctl: 7'b0010000, fw: 2'b01, cond: 4'b0000, aluc: 2'd0,
        rd1: 32'h55, rd2: 32'h66, imm: 32'h77, ra1: 4'h1, ra2: 4'h2, wa3: 4'h9};
    localparam dvals_t VINV = '{ctl: 7'b1000000, fw: 2'b11, cond: 4'b0101, aluc: 2'd3,
        rd1: 32'h1234_5678, rd2: 32'h9, imm: 32'hABC, ra1: 4'h1, ra2: 4'h2, wa3: 4'h4};
    localparam dvals_t VINV_E = '{ctl: 7'b0, fw: 2'b00, cond: 4'b1110, aluc: 2'd0,
        rd1: 32'h1234_5678, rd2: 32'h9, imm: 32'hABC, ra1: 4'h1, ra2: 4'h2, wa3: 4'h4};
    localparam dvals_t VFULL = '{ctl: 7'b1111111, fw: 2'b10, cond: 4'b1111, aluc: 2'd2,
        rd1: 32'hDEAD_BEEF, rd2: 32'hCAFE_F00D, imm: 32'hFF, ra1: 4'hA, ra2: 4'hB, wa3: 4'hF};
    localparam dvals_t VK = '{ctl: 7'b0000001, fw: 2'b01, cond: 4'b1010, aluc: 2'd1,
        rd1: 32'h1, rd2: 32'h2, imm: 32'h3, ra1: 4'hC, ra2: 4'hD, wa3: 4'hE};

    logic        CLK = 1'b0;
    logic        RESET, StallE, FlushE, ValidD;
    logic        PCSrcD, RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD, NoWriteD;
    logic [1:0]  FlagWriteD;
    logic [3:0]  CondD;
    logic [1:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, ExtImmD;
    logic [3:0]  RA1D, RA2D, WA3D;
    logic        PCSrcEIn, RegWriteEIn, MemWriteEIn, MemtoRegE, BranchEIn, ALUSrcE, NoWrite;
    logic [1:0]  FlagWriteE;
    logic [3:0]  CondE;
    logic [1:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ExtImmE;
    logic [3:0]  RA1E, RA2E, WA3E;
    logic        ValidE;
`ifdef DEX_BUBBLE_CNT_EN
    logic [15:0] BubbleCntE;
`endif

    int checks = 0;
    int errors = 0;
    dvals_t act;
    vec_t   tbl [11];

    decode_exec_reg dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .StallE      (StallE),
        .FlushE      (FlushE),
        .ValidD      (ValidD),
        .PCSrcD      (PCSrcD),
        .RegWriteD   (RegWriteD),
        .MemWriteD   (MemWriteD),
        .MemtoRegD   (MemtoRegD),
        .BranchD     (BranchD),
        .ALUSrcD     (ALUSrcD),
        .NoWriteD    (NoWriteD),
        .FlagWriteD  (FlagWriteD),
        .CondD       (CondD),
        .ALUControlD (ALUControlD),
        .RD1D        (RD1D),
        .RD2D        (RD2D),
        .ExtImmD     (ExtImmD),
        .RA1D        (RA1D),
        .RA2D        (RA2D),
        .WA3D        (WA3D),
        .PCSrcEIn    (PCSrcEIn),
        .RegWriteEIn (RegWriteEIn),
        .MemWriteEIn (MemWriteEIn),
        .MemtoRegE   (MemtoRegE),
        .BranchEIn   (BranchEIn),
        .ALUSrcE     (ALUSrcE),
        .NoWrite     (NoWrite),
        .FlagWriteE  (FlagWriteE),
        .CondE       (CondE),
        .ALUControlE (ALUControlE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ExtImmE     (ExtImmE),
        .RA1E        (RA1E),
        .RA2E        (RA2E),
        .WA3E        (WA3E),
`ifdef DEX_BUBBLE_CNT_EN
        .BubbleCntE  (BubbleCntE),
`endif
        .ValidE      (ValidE)
    );

    always #5 CLK = ~CLK;

    assign act = {PCSrcEIn, RegWriteEIn, MemWriteEIn, MemtoRegE, BranchEIn, ALUSrcE, NoWrite,
                  FlagWriteE, CondE, ALUControlE, RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E};

    task automatic cmp(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic check(input string tag, input dvals_t e, input logic ev);
        cmp({tag, ".ctrl"}, 128'({act.ctl, act.fw, act.cond, act.aluc}),
            128'({e.ctl, e.fw, e.cond, e.aluc}));
        cmp({tag, ".data"}, 128'({act.rd1, act.rd2, act.imm, act.ra1, act.ra2, act.wa3}),
            128'({e.rd1, e.rd2, e.imm, e.ra1, e.ra2, e.wa3}));
        cmp({tag, ".valid"}, 128'(ValidE), 128'(ev));
    endtask

    task automatic drive(input logic st, input logic fl, input logic vd, input dvals_t d);
        StallE = st;
        FlushE = fl;
        ValidD = vd;
        {PCSrcD, RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD, NoWriteD,
         FlagWriteD, CondD, ALUControlD, RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D} = d;
    endtask

    initial begin
        // Sequential table: each row is applied for one edge, expectations follow history.
        tbl[0]  = '{1'b0, 1'b0, 1'b1, VA,    VA,     1'b1};  // normal load
        tbl[1]  = '{1'b1, 1'b0, 1'b1, VB,    VA,     1'b1};  // stall x3
        tbl[2]  = '{1'b1, 1'b0, 1'b1, VB,    VA,     1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, VB,    VA,     1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, VB,    VB,     1'b1};  // stall released
        tbl[5]  = '{1'b1, 1'b1, 1'b1, VC,    BUB,    1'b0};  // flush beats stall
        tbl[6]  = '{1'b0, 1'b0, 1'b0, VINV,  VINV_E, 1'b0};  // invalid slot
        tbl[7]  = '{1'b0, 1'b0, 1'b1, VFULL, VFULL,  1'b1};  // all ones, cond NV passes
        tbl[8]  = '{1'b1, 1'b0, 1'b0, VINV,  VFULL,  1'b1};  // stall with invalid D
        tbl[9]  = '{1'b0, 1'b1, 1'b1, VK,    BUB,    1'b0};  // flush alone
        tbl[10] = '{1'b0, 1'b0, 1'b1, VK,    VK,     1'b1};

        // Reset with active D inputs, before any clock edge.
        RESET = 1'b1;
        drive(1'b0, 1'b0, 1'b1, VFULL);
        #1;
        check("reset_no_edge", BUB, 1'b0);
        @(negedge CLK);
        check("reset_held_edge", BUB, 1'b0);
`ifdef DEX_BUBBLE_CNT_EN
        cmp("cnt_reset", 128'(BubbleCntE), 128'(16'd0));
`endif
        RESET = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].stall, tbl[i].flush, tbl[i].vd, tbl[i].d);
            @(negedge CLK);
            check($sformatf("vec%0d", i), tbl[i].e, tbl[i].e_valid);
        end
`ifdef DEX_BUBBLE_CNT_EN
        cmp("cnt_after_table", 128'(BubbleCntE), 128'(16'd3));
`endif

        // Asynchronous reset mid-cycle after a load.
        drive(1'b0, 1'b0, 1'b1, VFULL);
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        check("reset_mid_cycle", BUB, 1'b0);
        drive(1'b1, 1'b1, 1'b1, VC);
        @(negedge CLK);
        check("reset_over_stall_flush", BUB, 1'b0);
        RESET = 1'b0;
        drive(1'b0, 1'b0, 1'b1, VA);
        @(negedge CLK);
        check("load_after_reset", VA, 1'b1);

`ifdef DEX_BUBBLE_CNT_EN
        cmp("cnt_zero_after_reset", 128'(BubbleCntE), 128'(16'd0));
        drive(1'b1, 1'b1, 1'b1, VC);
        @(negedge CLK);
        cmp("cnt_first_flush", 128'(BubbleCntE), 128'(16'd1));
        for (int i = 0; i < 65536; i++) @(negedge CLK);
        cmp("cnt_saturated", 128'(BubbleCntE), 128'(16'hFFFF));
        @(negedge CLK);
        cmp("cnt_stays_saturated", 128'(BubbleCntE), 128'(16'hFFFF));
        #2 RESET = 1'b1;
        #1;
        cmp("cnt_async_reset", 128'(BubbleCntE), 128'(16'd0));
        RESET = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_exec_reg.md
Name: decode_exec_reg

Overview:
- Decode→Execute pipeline register of the pipelined ARM-subset core.
- Captures decode-stage control, condition field, operands and register addresses each cycle.
- Presents them as the *E signals consumed by the conditional-execution unit and the ALU.
- Supports hold (stall) and bubble insertion (flush), and tracks a valid bit per slot.

Parameters:
- WIDTH, 32, data path width of RD1/RD2/ExtImm.
- RA_W, 4, register address width.
- ALUC_W, 2, ALU control width.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- StallE  in  1  hold the current E contents (enable low).
- FlushE  in  1  replace the next E contents with a bubble.
- ValidD  in  1  decode slot holds a real instruction.
- PCSrcD, RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD, NoWriteD  in  1 each  decode control.
- FlagWriteD  in  2  flag-group write enables: [1] = NZ, [0] = CV.
- CondD  in  4  instruction condition field.
- ALUControlD  in  ALUC_W  ALU operation.
- RD1D, RD2D, ExtImmD  in  WIDTH each  operands and extended immediate.
- RA1D, RA2D, WA3D  in  RA_W each  source and destination register addresses.
- The same set of outputs with the E suffix (PCSrcEIn, RegWriteEIn, MemWriteEIn, BranchEIn, NoWrite, FlagWriteE, CondE, …)  out  same widths.
- ValidE  out  1  E slot holds a real instruction.

Behaviour:
- Reset: on RESET high, asynchronously and immediately:
  - all outputs are 0, except CondE = 4'b1110 (AL).
  - ValidE = 0.
  - Reset mid-stall or mid-flush overrides both.
- Latency: one cycle. A D value sampled at rising edge n appears on E after edge n.
- Priority at each rising edge, RESET low:
  1. FlushE = 1 → bubble. All control outputs = 0, FlagWriteE = 0, CondE = AL, data and addresses = 0, ValidE = 0. Flush wins over StallE when both are high.
  2. Else StallE = 1 → every E register holds its value. ValidE holds.
  3. Else → load all D inputs. ValidE = ValidD.
- Bubble definition: a bubble never writes the register file, memory or flags, and never redirects the PC.
- Invalid instructions: if ValidD = 0 on a load, control bits are forced to 0 and CondE = AL, so an invalid slot is a bubble. Data fields still load (don't-care).
- Bubble CondE: a bubble never presents CondE = 4'b1111. Any CondD = 4'b1111 with ValidD = 1 passes through unchanged; the downstream unit treats it as undefined.
- Widths: all fields are pure pass-through, with no arithmetic and no width conversion.
- Glitch-free: every E output is a flop output, with no combinational path from D to E.
- Two-state FSM per slot, encoded in ValidE:
  - EMPTY (ValidE = 0) → FULL on load with ValidD = 1.
  - FULL → EMPTY on flush, or on load with ValidD = 0.
  - Stall keeps the current state.

Optional Feature:
- Macro: DEX_BUBBLE_CNT_EN.
- When defined: adds output BubbleCntE (16 bits).
  - Increments by 1 on each rising edge where the E slot becomes or remains a bubble because of FlushE = 1, or because of a load with ValidD = 0.
  - Saturates at 16'hFFFF with no wrap.
  - Holds during a stall without flush.
  - Resets to 0 asynchronously with RESET.
- When undefined: the port and counter are absent and the remaining behaviour is identical.

Decomposition:
- Package dex_pkg holds:
  - COND_AL = 4'b1110.
  - ALUC_W default.
  - typedef struct packed ctrl_t grouping PCSrc, RegWrite, MemWrite, MemtoReg, Branch, ALUSrc, NoWrite, FlagWrite[1:0], Cond[3:0], ALUControl.
  - BUBBLE_CTRL constant: all control 0, Cond = COND_AL.
- One natural sub-module: flopenrc, a parameterised flop with async reset, enable and synchronous clear.
  - Instantiated for ctrl_t, for data, and for the valid bit.
  - The reset/clear value is a parameter, so the ctrl instance clears to BUBBLE_CTRL.

Test Plan:
1. Reset: assert RESET mid-cycle with D inputs active → all outputs 0, CondE = 4'b1110, ValidE = 0, with no clock edge needed.
2. Normal load: ValidD = 1, RegWriteD = 1, CondD = 4'b0000, RD1D = 32'h0000_00A5, WA3D = 4'd3 → after one edge RegWriteEIn = 1, CondE = 0000, RD1E = 32'hA5, WA3E = 3, ValidE = 1.
3. Stall: load as in scenario 2, then StallE = 1 for 3 edges while D changes to RD1D = 32'hFFFF_FFFF → E stays at 32'hA5 and ValidE = 1. After StallE drops, the next edge loads 32'hFFFF_FFFF.
4. Flush with stall: FlushE = 1 and StallE = 1 on the same edge with a valid MemWriteD = 1 → MemWriteEIn = 0, CondE = AL, ValidE = 0. With DEX_BUBBLE_CNT_EN, BubbleCntE increments 0→1.
5. Invalid slot: ValidD = 0 with PCSrcD = 1, FlagWriteD = 2'b11 → PCSrcEIn = 0, FlagWriteE = 00, ValidE = 0.
6. Counter saturation (DEX_BUBBLE_CNT_EN): force 65537 consecutive flush edges → BubbleCntE = 16'hFFFF and stays there. After RESET, BubbleCntE = 0.
